// File: rtl/chunked_adder_pkg.sv
// Shared state encoding and chunk-count helpers for the chunked adder.
// Latency: n/a. Backpressure: n/a.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index register needs at least one bit even when there is a single chunk.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// CHUNK-bit ripple adder built from full_adder cells; c_msb is the carry into bit CHUNK-1.
// Latency: combinational. Backpressure: none.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Latency: combinational. Backpressure: none.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle add/sub, CHUNK bits per cycle; done pulses WIDTH/CHUNK+1 cycles after start.
// start is ignored while busy or done; CHUNKED_ADDER_OVF_EN enables the signed overflow flag.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = chunk_count(WIDTH, CHUNK);
    localparam int IW = index_width(N);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             last;

    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK-1:0] y_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;
    logic             cmsb_chunk;

    assign last = (idx == IW'(N - 1));

    always_comb begin
        x_chunk = '0;
        y_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                x_chunk = opa[i*CHUNK +: CHUNK];
                y_chunk = opb[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .x     (x_chunk),
        .y     (y_chunk),
        .ci    (carry),
        .s     (s_chunk),
        .co    (co_chunk),
        .c_msb (cmsb_chunk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Subtraction is a + ~b + 1: invert B at capture and force the first carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b ^ {WIDTH{sub}};
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IW'(i)) sum[i*CHUNK +: CHUNK] <= s_chunk;
                    end
                    carry <= co_chunk;
                    idx   <= idx + IW'(1);
                    if (last) cout <= co_chunk;
                end
                default: ;
            endcase
        end
    end

`ifdef CHUNKED_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == ST_RUN && last) begin
            ovf_q <= co_chunk ^ cmsb_chunk;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_cmsb;

    assign unused_cmsb = cmsb_chunk;
    assign ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench: four parameterisations of chunked_adder against an arithmetic reference.
module tb_chunked_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [4];
    logic        start_v [4];
    logic        sub_v   [4];
    logic        cin_v   [4];
    logic [31:0] a_v     [4];
    logic [31:0] b_v     [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic        cout_v  [4];
    logic        ovf_v   [4];
    logic [31:0] sum_v   [4];

    int checks   = 0;
    int failures = 0;

    function automatic int wof(input int g);
        return (g == 3) ? 32 : 16;
    endfunction

    function automatic int cof(input int g);
        case (g)
            0:       return 1;
            1:       return 4;
            2:       return 16;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 3) ? 32 : 16;
        localparam int C = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 16 : 8;
        logic [W-1:0] s_w;

        chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
            .clk   (clk),
            .rst   (rst_v[g]),
            .start (start_v[g]),
            .sub   (sub_v[g]),
            .a     (a_v[g][W-1:0]),
            .b     (b_v[g][W-1:0]),
            .cin   (cin_v[g]),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .sum   (s_w),
            .cout  (cout_v[g]),
            .ovf   (ovf_v[g])
        );

        assign sum_v[g] = 32'(s_w);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic, signed overflow from operand/result sign bits.
    function automatic void ref_model(input int w, input logic s, input logic [31:0] aa,
                                      input logic [31:0] bb, input logic c,
                                      output logic [31:0] es, output logic ec, output logic eo);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bx;
        logic [32:0] full;
        mask = 32'((64'd1 << w) - 64'd1);
        am   = aa & mask;
        bx   = (s ? ~bb : bb) & mask;
        full = {1'b0, am} + {1'b0, bx} + 33'(s ? 1'b1 : c);
        es   = full[31:0] & mask;
        ec   = full[w];
`ifdef CHUNKED_ADDER_OVF_EN
        eo   = (am[w-1] == bx[w-1]) && (es[w-1] != am[w-1]);
`else
        eo   = 1'b0;
`endif
    endfunction

    task automatic check_reset_outputs(input int g, input string tag);
        check({tag, "_busy"}, 64'(busy_v[g]), 64'd0);
        check({tag, "_done"}, 64'(done_v[g]), 64'd0);
        check({tag, "_sum"},  64'(sum_v[g]),  64'd0);
        check({tag, "_cout"}, 64'(cout_v[g]), 64'd0);
        check({tag, "_ovf"},  64'(ovf_v[g]),  64'd0);
    endtask

    task automatic run_op(input int g, input logic s, input logic [31:0] aa, input logic [31:0] bb,
                          input logic c, input bit intrude, input string tag);
        logic [31:0] es;
        logic        ec;
        logic        eo;
        int          n;
        int          lat;
        int          nb;
        bit          got;
        n = wof(g) / cof(g);
        ref_model(wof(g), s, aa, bb, c, es, ec, eo);
        @(negedge clk);
        start_v[g] = 1'b1;
        sub_v[g]   = s;
        a_v[g]     = aa;
        b_v[g]     = bb;
        cin_v[g]   = c;
        lat = 0;
        nb  = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start_v[g] = 1'b0;
                a_v[g]     = $urandom;
                b_v[g]     = $urandom;
                cin_v[g]   = 1'($urandom);
                sub_v[g]   = 1'($urandom);
            end
            if (intrude && lat == 2) begin
                start_v[g] = 1'b1;
                a_v[g]     = ~aa;
                b_v[g]     = bb ^ 32'h5a5a_5a5a;
                sub_v[g]   = ~s;
            end
            if (intrude && lat == 3) start_v[g] = 1'b0;
            if (busy_v[g]) nb++;
            if (done_v[g]) got = 1'b1;
        end
        start_v[g] = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"},   64'(lat), 64'(n + 1));
        check({tag, "_busy_cyc"},  64'(nb),  64'(n));
        check({tag, "_sum"},       64'(sum_v[g]),  64'(es));
        check({tag, "_cout"},      64'(cout_v[g]), 64'(ec));
        check({tag, "_ovf"},       64'(ovf_v[g]),  64'(eo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done_v[g]), 64'd0);
        check({tag, "_idle_busy"},  64'(busy_v[g]), 64'd0);
        check({tag, "_sum_held"},   64'(sum_v[g]),  64'(es));
    endtask

    initial begin
        bit seen;
        for (int g = 0; g < 4; g++) begin
            rst_v[g] = 1'b1; start_v[g] = 1'b0; sub_v[g] = 1'b0; cin_v[g] = 1'b0;
            a_v[g] = '0; b_v[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) check_reset_outputs(g, "reset");
        for (int g = 0; g < 4; g++) rst_v[g] = 1'b0;

        // Directed cases on the 16/4 instance.
        run_op(1, 1'b0, 32'h1234, 32'h4321, 1'b0, 1'b0, "add_5555");
        run_op(1, 1'b0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, "add_carry_chain");
        run_op(1, 1'b0, 32'h0000, 32'h0000, 1'b1, 1'b0, "add_cin");
        run_op(1, 1'b1, 32'h0005, 32'h0007, 1'b1, 1'b0, "sub_borrow");
        run_op(1, 1'b1, 32'h0007, 32'h0005, 1'b0, 1'b0, "sub_noborrow");
        run_op(1, 1'b0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, "ovf_add");
        run_op(1, 1'b1, 32'h8000, 32'h0001, 1'b0, 1'b0, "ovf_sub");
        run_op(1, 1'b0, 32'h0F0F, 32'h00F1, 1'b1, 1'b1, "start_in_run");

        // Abort in the second RUN cycle.
        @(negedge clk);
        start_v[1] = 1'b1; a_v[1] = 32'hABCD; b_v[1] = 32'h1111; sub_v[1] = 1'b0; cin_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        check_reset_outputs(1, "abort");
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_v[1] || busy_v[1]) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run_op(1, 1'b0, 32'h0102, 32'h0304, 1'b0, 1'b0, "after_abort");

        // start together with rst must be dropped.
        @(negedge clk);
        rst_v[1] = 1'b1; start_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0; start_v[1] = 1'b0;
        check_reset_outputs(1, "start_with_rst");
        @(negedge clk);
        check("start_with_rst_idle", 64'(busy_v[1]), 64'd0);

        // Random sweep across every parameterisation.
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 250; i++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                ra = $urandom;
                rb = $urandom;
                if (i % 50 == 0) begin
                    ra = 32'hFFFF_FFFF;
                    rb = 32'(i / 50);
                end
                run_op(g, 1'($urandom), ra, rb, 1'($urandom), 1'b0, $sformatf("rand_g%0d_%0d", g, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
